// File: rtl/stage_3_ex.sv
// Execute stage: bundle register, ALU, iterative radix-2 divider and data-SRAM request.
// Define STAGE3_DIV_EN to build the divider; without it div_op is ignored and ready_go_3 = 1.
module stage_3_ex (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_2,
    output logic         allow_3,
    output logic         valid_3,
    input  logic         allow_4,
    input  logic [150:0] stage_2_to_3,
    output logic [38:0]  stage_3_to_4,
    output logic [31:0]  alu_result,
    output logic         data_sram_en,
    output logic [3:0]   data_sram_we,
    output logic [31:0]  data_sram_addr,
    output logic [31:0]  data_sram_wdata
);

    logic [150:0] bundle_q;
    logic [2:0]   div_op;
    logic [11:0]  alu_op;
    logic [31:0]  alu_src1;
    logic [31:0]  alu_src2;
    logic         mem_we;
    logic [31:0]  rkd_value;
    logic         rf_we;
    logic [4:0]   dest;
    logic         res_from_mem;
    logic [31:0]  pc;
    logic         ready_go_3;
    logic [31:0]  alu_out;

    assign {div_op, alu_op, alu_src1, alu_src2, mem_we, rkd_value,
            rf_we, dest, res_from_mem, pc} = bundle_q;

    assign allow_3 = !valid_3 || (ready_go_3 && allow_4);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_3  <= 1'b0;
            bundle_q <= '0;
        end else begin
            if (allow_3)
                valid_3 <= valid_2;
            if (valid_2 && allow_3)
                bundle_q <= stage_2_to_3;
        end
    end

    // One-hot ALU: each op contributes under its select bit, so all-zero alu_op yields 0.
    logic [31:0] add_res, sub_res, sra_res;
    logic        slt_res, sltu_res;

    assign add_res  = alu_src1 + alu_src2;
    assign sub_res  = alu_src1 - alu_src2;
    assign slt_res  = $signed(alu_src1) < $signed(alu_src2);
    assign sltu_res = alu_src1 < alu_src2;
    assign sra_res  = $unsigned($signed(alu_src1) >>> alu_src2[4:0]);

    assign alu_out = ({32{alu_op[0]}}  & add_res)
                   | ({32{alu_op[1]}}  & sub_res)
                   | ({32{alu_op[2]}}  & {31'd0, slt_res})
                   | ({32{alu_op[3]}}  & {31'd0, sltu_res})
                   | ({32{alu_op[4]}}  & (alu_src1 & alu_src2))
                   | ({32{alu_op[5]}}  & ~(alu_src1 | alu_src2))
                   | ({32{alu_op[6]}}  & (alu_src1 | alu_src2))
                   | ({32{alu_op[7]}}  & (alu_src1 ^ alu_src2))
                   | ({32{alu_op[8]}}  & (alu_src1 << alu_src2[4:0]))
                   | ({32{alu_op[9]}}  & (alu_src1 >> alu_src2[4:0]))
                   | ({32{alu_op[10]}} & sra_res)
                   | ({32{alu_op[11]}} & alu_src2);

`ifdef STAGE3_DIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t  div_state, div_next;
    logic [4:0]  div_cnt;
    logic [31:0] div_q, div_r, div_d;
    logic        is_div, src1_neg, src2_neg;
    logic [31:0] abs1, abs2, quot, rem;
    logic [32:0] trial;

    assign is_div     = div_op[2];
    assign ready_go_3 = !is_div || (div_state == DONE);
    assign src1_neg   = div_op[1] && alu_src1[31];
    assign src2_neg   = div_op[1] && alu_src2[31];
    assign abs1       = src1_neg ? -alu_src1 : alu_src1;
    assign abs2       = src2_neg ? -alu_src2 : alu_src2;
    assign trial      = {div_r, div_q[31]} - {1'b0, div_d};

    always_ff @(posedge clk) begin
        if (reset)
            div_state <= IDLE;
        else
            div_state <= div_next;
    end

    always_comb begin
        div_next = div_state;
        case (div_state)
            IDLE:    if (valid_3 && is_div) div_next = BUSY;
            BUSY:    if (div_cnt == 5'd31)  div_next = DONE;
            DONE:    if (valid_3 && allow_4) div_next = IDLE;
            default: div_next = IDLE;
        endcase
    end

    // Restoring step: remainder shifts in the next dividend bit; keep the difference if no borrow.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            div_q   <= '0;
            div_r   <= '0;
            div_d   <= '0;
        end else if (div_state == IDLE) begin
            if (valid_3 && is_div) begin
                div_cnt <= '0;
                div_q   <= abs1;
                div_r   <= '0;
                div_d   <= abs2;
            end
        end else if (div_state == BUSY) begin
            div_cnt <= div_cnt + 5'd1;
            div_q   <= {div_q[30:0], ~trial[32]};
            div_r   <= trial[32] ? {div_r[30:0], div_q[31]} : trial[31:0];
        end
    end

    always_comb begin
        quot = (src1_neg ^ src2_neg) ? -div_q : div_q;
        rem  = src1_neg ? -div_r : div_r;
        if (alu_src2 == '0) begin
            quot = '1;
            rem  = alu_src1;
        end
    end

    assign alu_result = is_div ? (div_op[0] ? rem : quot) : alu_out;
`else
    logic unused_div_op;

    assign unused_div_op = ^div_op;
    assign ready_go_3    = 1'b1;
    assign alu_result    = alu_out;
`endif

    assign stage_3_to_4    = {rf_we, dest, res_from_mem, pc};
    assign data_sram_en    = valid_3 && (res_from_mem || mem_we) && ready_go_3 && allow_4;
    assign data_sram_we    = {4{valid_3 && mem_we && allow_4}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_value;

endmodule

// File: tb/tb_stage_3_ex.sv
// Directed self-checking bench for stage_3_ex; expectations follow STAGE3_DIV_EN when defined.
module tb_stage_3_ex;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_2;
    logic         allow_3;
    logic         valid_3;
    logic         allow_4;
    logic [150:0] stage_2_to_3;
    logic [38:0]  stage_3_to_4;
    logic [31:0]  alu_result;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int tests = 0;
    int fails = 0;

`ifdef STAGE3_DIV_EN
    localparam int DLAT = 34;
`else
    localparam int DLAT = 1;
`endif

    stage_3_ex dut (
        .clk             (clk),
        .reset           (reset),
        .valid_2         (valid_2),
        .allow_3         (allow_3),
        .valid_3         (valid_3),
        .allow_4         (allow_4),
        .stage_2_to_3    (stage_2_to_3),
        .stage_3_to_4    (stage_3_to_4),
        .alu_result      (alu_result),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [150:0] mk(input logic [2:0] dop, input logic [11:0] aop,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic we, input logic [31:0] rkd,
                                        input logic rfwe, input logic [4:0] dst,
                                        input logic rfm, input logic [31:0] pcv);
        return {dop, aop, s1, s2, we, rkd, rfwe, dst, rfm, pcv};
    endfunction

    // Present a bundle for one edge; caller guarantees allow_3 is high.
    task automatic issue(input logic [150:0] b);
        valid_2      = 1'b1;
        stage_2_to_3 = b;
        @(posedge clk); #1;
        valid_2      = 1'b0;
    endtask

    // Sample each cycle until the stage can hand over; bounded by a cycle budget.
    task automatic wait_handover(output logic [31:0] res, output int cyc, output int stl, output bit to);
        cyc = 0; stl = 0; to = 1'b0; res = '0;
        while (1) begin
            cyc++;
            if (!allow_3) stl++;
            if (allow_3) begin
                res = alu_result;
                break;
            end
            if (cyc >= 200) begin
                to = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; valid_2 = 1'b0; allow_4 = 1'b1; stage_2_to_3 = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (valid_3 !== 1'b0) begin fails++; $display("FAIL reset_valid_3: got %b want 0", valid_3); end
        tests++; if (allow_3 !== 1'b1) begin fails++; $display("FAIL reset_allow_3: got %b want 1", allow_3); end
        tests++; if (data_sram_en !== 1'b0) begin fails++; $display("FAIL reset_sram_en: got %b want 0", data_sram_en); end
        tests++; if (data_sram_we !== 4'h0) begin fails++; $display("FAIL reset_sram_we: got %h want 0", data_sram_we); end
        tests++; if (alu_result !== 32'h0) begin fails++; $display("FAIL reset_alu_result: got %h want 0", alu_result); end
        tests++; if (stage_3_to_4 !== 39'h0) begin fails++; $display("FAIL reset_stage_3_to_4: got %h want 0", stage_3_to_4); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        allow_4 = 1'b1;
        issue(mk(3'b000, 12'h001, 32'h5, 32'hFFFFFFFE, 1'b0, 32'h0, 1'b1, 5'd7, 1'b0, 32'h1C000000));
        tests++; if (valid_3 !== 1'b1) begin fails++; $display("FAIL add_valid_3: got %b want 1", valid_3); end
        tests++; if (alu_result !== 32'h3) begin fails++; $display("FAIL add_result: got %h want 00000003", alu_result); end
        tests++; if (data_sram_en !== 1'b0) begin fails++; $display("FAIL add_sram_en: got %b want 0", data_sram_en); end
        tests++; if (stage_3_to_4 !== {1'b1, 5'd7, 1'b0, 32'h1C000000}) begin
            fails++; $display("FAIL add_stage_3_to_4: got %h want %h", stage_3_to_4, {1'b1, 5'd7, 1'b0, 32'h1C000000}); end
        @(posedge clk); #1;
        tests++; if (valid_3 !== 1'b0) begin fails++; $display("FAIL add_latency: valid_3 got %b want 0", valid_3); end
    endtask

    task automatic test_alu_ops;
        logic [11:0] ops [12] = '{12'h002, 12'h004, 12'h008, 12'h010, 12'h020, 12'h040,
                                  12'h080, 12'h100, 12'h200, 12'h400, 12'h800, 12'h000};
        logic [31:0] exp [12] = '{32'hF0000002, 32'h00000001, 32'h00000000, 32'h00000001,
                                  32'h0FFFFFF8, 32'hF0000007, 32'hF0000006, 32'h80000028,
                                  32'h1E000000, 32'hFE000000, 32'h00000003, 32'h00000000};
        allow_4 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            issue(mk(3'b000, ops[i], 32'hF0000005, 32'h3, 1'b0, 32'h0, 1'b1, 5'd1, 1'b0, 32'h100 + i));
            tests++; if (alu_result !== exp[i]) begin
                fails++; $display("FAIL alu_op_%03h: got %h want %h", ops[i], alu_result, exp[i]); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store;
        int pulses;
        allow_4 = 1'b1;
        issue(mk(3'b000, 12'h001, 32'h1000, 32'h4, 1'b1, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 32'h1C000010));
        tests++; if (data_sram_en !== 1'b1) begin fails++; $display("FAIL store_en: got %b want 1", data_sram_en); end
        tests++; if (data_sram_we !== 4'hF) begin fails++; $display("FAIL store_we: got %h want f", data_sram_we); end
        tests++; if (data_sram_addr !== 32'h1004) begin fails++; $display("FAIL store_addr: got %h want 00001004", data_sram_addr); end
        tests++; if (data_sram_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL store_wdata: got %h want deadbeef", data_sram_wdata); end
        pulses = int'(data_sram_en);
        repeat (3) begin
            @(posedge clk); #1;
            pulses += int'(data_sram_en);
        end
        tests++; if (pulses != 1) begin fails++; $display("FAIL store_once: got %0d pulses want 1", pulses); end
    endtask

    task automatic test_div;
        logic [2:0]  dop [6] = '{3'b110, 3'b111, 3'b100, 3'b101, 3'b110, 3'b111};
        logic [31:0] s1  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h12345678, 32'h12345678, 32'h80000000, 32'h80000000};
        logic [31:0] s2  [6] = '{32'h2, 32'h2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
`ifdef STAGE3_DIV_EN
        logic [31:0] exp [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h00000000};
`else
        logic [31:0] exp [6] = '{32'hFFFFFFFB, 32'hFFFFFFFB, 32'h12345678, 32'h12345678, 32'h7FFFFFFF, 32'h7FFFFFFF};
`endif
        logic [31:0] res;
        int cyc, stl;
        bit to;
        allow_4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            issue(mk(dop[i], 12'h001, s1[i], s2[i], 1'b0, 32'h0, 1'b1, 5'd2, 1'b0, 32'h200 + i));
            wait_handover(res, cyc, stl, to);
            tests++; if (to) begin fails++; $display("FAIL div%0d_timeout: no handover within budget", i); end
            tests++; if (res !== exp[i]) begin fails++; $display("FAIL div%0d_result: got %h want %h", i, res, exp[i]); end
            tests++; if (cyc != DLAT) begin fails++; $display("FAIL div%0d_valid_cycles: got %0d want %0d", i, cyc, DLAT); end
            tests++; if (stl != DLAT - 1) begin fails++; $display("FAIL div%0d_stall_cycles: got %0d want %0d", i, stl, DLAT - 1); end
            tests++; if (data_sram_en !== 1'b0) begin fails++; $display("FAIL div%0d_sram_en: got %b want 0", i, data_sram_en); end
            @(posedge clk); #1;
            tests++; if (valid_3 !== 1'b0) begin fails++; $display("FAIL div%0d_leave: valid_3 got %b want 0", i, valid_3); end
        end
    endtask

    task automatic test_done_hold;
        localparam int HOLD = DLAT + 4;
`ifdef STAGE3_DIV_EN
        logic [31:0] expv = 32'h0000000E;
`else
        logic [31:0] expv = 32'h0000006B;
`endif
        int pulses = 0;
        allow_4 = 1'b0;
        issue(mk(3'b100, 12'h001, 32'd100, 32'd7, 1'b0, 32'h0, 1'b1, 5'd3, 1'b1, 32'h1C000040));
        for (int c = 0; c < HOLD; c++) begin
            pulses += int'(data_sram_en);
            tests++; if (data_sram_en !== 1'b0) begin fails++; $display("FAIL hold_sram_en_c%0d: got %b want 0", c, data_sram_en); end
            if (c >= HOLD - 5) begin
                tests++; if (alu_result !== expv) begin fails++; $display("FAIL hold_result_c%0d: got %h want %h", c, alu_result, expv); end
                tests++; if (stage_3_to_4[31:0] !== 32'h1C000040) begin
                    fails++; $display("FAIL hold_pc_c%0d: got %h want 1c000040", c, stage_3_to_4[31:0]); end
            end
            valid_2      = 1'b1;
            stage_2_to_3 = mk(3'b000, 12'h001, 32'h1, 32'h1, 1'b0, 32'h0, 1'b0, 5'd9, 1'b0, 32'h0000BAD0);
            @(posedge clk); #1;
        end
        valid_2 = 1'b0;
        allow_4 = 1'b1;
        #1;
        pulses += int'(data_sram_en);
        tests++; if (data_sram_en !== 1'b1) begin fails++; $display("FAIL hold_release_en: got %b want 1", data_sram_en); end
        tests++; if (alu_result !== expv) begin fails++; $display("FAIL hold_release_result: got %h want %h", alu_result, expv); end
        @(posedge clk); #1;
        pulses += int'(data_sram_en);
        tests++; if (valid_3 !== 1'b0) begin fails++; $display("FAIL hold_leave: valid_3 got %b want 0", valid_3); end
        tests++; if (pulses != 1) begin fails++; $display("FAIL hold_single_pulse: got %0d want 1", pulses); end
    endtask

    task automatic test_reset_mid_div;
        logic [31:0] res;
        int cyc, stl;
        bit to;
        allow_4 = 1'b1;
        issue(mk(3'b110, 12'h001, 32'hFFFFFFF9, 32'h2, 1'b0, 32'h0, 1'b1, 5'd4, 1'b1, 32'h300));
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests++; if (valid_3 !== 1'b0) begin fails++; $display("FAIL rst_mid_valid_3: got %b want 0", valid_3); end
        tests++; if (allow_3 !== 1'b1) begin fails++; $display("FAIL rst_mid_allow_3: got %b want 1", allow_3); end
        tests++; if (data_sram_en !== 1'b0) begin fails++; $display("FAIL rst_mid_sram_en: got %b want 0", data_sram_en); end
        issue(mk(3'b000, 12'h001, 32'h1, 32'h2, 1'b0, 32'h0, 1'b1, 5'd5, 1'b0, 32'h304));
        tests++; if (alu_result !== 32'h3) begin fails++; $display("FAIL rst_mid_add_result: got %h want 00000003", alu_result); end
        @(posedge clk); #1;
        tests++; if (valid_3 !== 1'b0) begin fails++; $display("FAIL rst_mid_add_latency: valid_3 got %b want 0", valid_3); end
        issue(mk(3'b110, 12'h001, 32'hFFFFFFF9, 32'h2, 1'b0, 32'h0, 1'b1, 5'd4, 1'b0, 32'h308));
        wait_handover(res, cyc, stl, to);
        tests++; if (to) begin fails++; $display("FAIL rst_mid_redo_timeout: no handover within budget"); end
        tests++; if (cyc != DLAT) begin fails++; $display("FAIL rst_mid_redo_cycles: got %0d want %0d", cyc, DLAT); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
`ifdef STAGE3_DIV_EN
        logic [31:0] exp_a = 32'hFFFFFFFF;
`else
        logic [31:0] exp_a = 32'hFFFFFFFB;
`endif
        logic [31:0] exp_b = 32'h12345678;
        logic [31:0] res;
        int cyc, stl;
        bit to;
        allow_4 = 1'b1;
        valid_2 = 1'b1;
        stage_2_to_3 = mk(3'b111, 12'h001, 32'hFFFFFFF9, 32'h2, 1'b0, 32'h0, 1'b1, 5'd6, 1'b0, 32'h400);
        @(posedge clk); #1;
        stage_2_to_3 = mk(3'b101, 12'h001, 32'h12345678, 32'h0, 1'b0, 32'h0, 1'b1, 5'd6, 1'b0, 32'h404);
        wait_handover(res, cyc, stl, to);
        tests++; if (to) begin fails++; $display("FAIL b2b_a_timeout: no handover within budget"); end
        tests++; if (res !== exp_a) begin fails++; $display("FAIL b2b_a_result: got %h want %h", res, exp_a); end
        tests++; if (cyc != DLAT) begin fails++; $display("FAIL b2b_a_cycles: got %0d want %0d", cyc, DLAT); end
        @(posedge clk); #1;
        valid_2 = 1'b0;
        tests++; if (valid_3 !== 1'b1) begin fails++; $display("FAIL b2b_b_accept: valid_3 got %b want 1", valid_3); end
        tests++; if (stage_3_to_4[31:0] !== 32'h404) begin fails++; $display("FAIL b2b_b_pc: got %h want 00000404", stage_3_to_4[31:0]); end
        wait_handover(res, cyc, stl, to);
        tests++; if (to) begin fails++; $display("FAIL b2b_b_timeout: no handover within budget"); end
        tests++; if (res !== exp_b) begin fails++; $display("FAIL b2b_b_result: got %h want %h", res, exp_b); end
        tests++; if (cyc != DLAT) begin fails++; $display("FAIL b2b_b_cycles: got %0d want %0d", cyc, DLAT); end
        @(posedge clk); #1;
        tests++; if (valid_3 !== 1'b0) begin fails++; $display("FAIL b2b_leave: valid_3 got %b want 0", valid_3); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_store();
        test_div();
        test_done_hold();
        test_reset_mid_div();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
